apb_write_sequencer: RTL

Write-path engine stage that drains a captured AXI write burst into APB write transfers. It is started with the burst's address info (addr/len/size/burst), then pops one data/strobe word per beat from the write-data FIFO. For each beat it runs one APB SETUP/ACCESS write, accumulating PSLVERR. When the last beat finishes it pulses done and reports the burst response, which the write-response stage returns on B.

---
 rtl/apb_write_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/apb_write_sequencer.sv
// apb_write_sequencer: drains a captured AXI write burst from a FWFT FIFO into APB
// write transfers and reports the accumulated burst response.
`default_nettype none

module apb_write_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              resp,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_rdata,
  input  logic [DATA_WIDTH/8-1:0] fifo_rstrb,
  output logic                    fifo_rd,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [3:0]            len_q;
  logic [3:0]            beat_q;
  logic [2:0]            size_q;
  logic [2:0]            size_clamped;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic                  accept;
  logic                  handshake;
  logic                  last_beat;

  assign accept       = (state == S_IDLE) && start;
  assign handshake    = (state == S_ACCESS) && pready;
  assign last_beat    = (beat_q == len_q);
  assign size_clamped = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;

  // Address step; WRAP keeps the upper bits and wraps within the burst-sized window.
  assign incr      = ADDR_WIDTH'(1) << size_q;
  assign addr_inc  = addr_q + incr;
  assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);

  always_comb begin
    addr_next = addr_inc;
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    fifo_rd    = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        psel       = 1'b1;
        state_next = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) state_next = last_beat ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign pwrite = psel;
  assign paddr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      resp    <= 2'b00;
      pwdata  <= '0;
      pstrb   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        len_q   <= cmd_len;
        size_q  <= size_clamped;
        burst_q <= cmd_burst;
        beat_q  <= '0;
        err_q   <= 1'b0;
        resp    <= 2'b00;
      end
      if (fifo_rd) begin
        pwdata <= fifo_rdata;
        pstrb  <= fifo_rstrb;
      end
      if (handshake) begin
        err_q <= err_q | pslverr;
        if (last_beat) begin
          resp <= (err_q | pslverr) ? 2'b10 : 2'b00;
        end else begin
          addr_q <= addr_next;
          beat_q <= beat_q + 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
